// File: rtl/id_stage_pkg.sv
// Shared decode constants, exception codes and ID/EX register layout for id_stage.
// Opcode/funct values follow the MIPS-I encoding for the supported subset.
package id_stage_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  localparam logic [4:0] ERR_NONE    = 5'd31;
  localparam logic [4:0] ERR_ADEL    = 5'd4;
  localparam logic [4:0] ERR_ADES    = 5'd5;
  localparam logic [4:0] ERR_SYSCALL = 5'd8;
  localparam logic [4:0] ERR_RI      = 5'd10;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LUI   = 6'h0f;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;
  localparam logic [5:0] FN_SYSCALL = 6'h0c;
  localparam logic [5:0] FN_ADDU    = 6'h21;
  localparam logic [5:0] FN_SUBU    = 6'h23;
  localparam logic [5:0] FN_AND     = 6'h24;
  localparam logic [5:0] FN_OR      = 6'h25;
  localparam logic [5:0] FN_SLT     = 6'h2a;

  typedef enum logic [1:0] {
    IMM_SEXT = 2'd0,
    IMM_ZEXT = 2'd1,
    IMM_LUI  = 2'd2
  } imm_kind_e;

  typedef struct packed {
    logic      legal;
    logic      is_branch;
    logic      is_beq;
    logic      is_jump_imm;
    logic      is_jump_reg;
    logic      is_ctrl;
    imm_kind_e imm_kind;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc8;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] imm32;
    logic        err;
    logic [4:0]  errstat;
  } idex_t;

  localparam idex_t IDEX_RESET = '{
    pc:      RESET_PC,
    pc8:     RESET_PC + 32'd8,
    instr:   32'd0,
    rs_val:  32'd0,
    rt_val:  32'd0,
    imm32:   32'd0,
    err:     1'b0,
    errstat: ERR_NONE
  };

  // Anything not matched below is a reserved instruction; nop decodes as sll.
  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn);
    dec_t d;
    d = '0;
    d.imm_kind = IMM_SEXT;
    case (op)
      OP_RTYPE: begin
        case (fn)
          FN_SLL, FN_SYSCALL, FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: d.legal = 1'b1;
          FN_JR, FN_JALR: begin
            d.legal       = 1'b1;
            d.is_jump_reg = 1'b1;
            d.is_ctrl     = 1'b1;
          end
          default: d.legal = 1'b0;
        endcase
      end
      OP_J, OP_JAL: begin
        d.legal       = 1'b1;
        d.is_jump_imm = 1'b1;
        d.is_ctrl     = 1'b1;
      end
      OP_BEQ, OP_BNE: begin
        d.legal     = 1'b1;
        d.is_branch = 1'b1;
        d.is_beq    = (op == OP_BEQ);
        d.is_ctrl   = 1'b1;
      end
      OP_ORI, OP_ANDI: begin
        d.legal    = 1'b1;
        d.imm_kind = IMM_ZEXT;
      end
      OP_LUI: begin
        d.legal    = 1'b1;
        d.imm_kind = IMM_LUI;
      end
      OP_ADDIU, OP_LW, OP_SW: d.legal = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_grf.sv
// 32x32 general register file: $0 hardwired to zero, synchronous write,
// combinational read ports with write-through of the same-cycle write.
module id_grf (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  rs_addr,
  input  logic [4:0]  rt_addr,
  output logic [31:0] rs_data,
  output logic [31:0] rt_data
);

  logic [31:0] regs [1:31];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= 32'd0;
      end
    end else if (we && (waddr != 5'd0)) begin
      regs[waddr] <= wdata;
    end
  end

  // Write-through saves a forwarding path from WB into ID.
  assign rs_data = (rs_addr == 5'd0)               ? 32'd0 :
                   (we && (rs_addr == waddr))       ? wdata : regs[rs_addr];
  assign rt_data = (rt_addr == 5'd0)               ? 32'd0 :
                   (we && (rt_addr == waddr))       ? wdata : regs[rt_addr];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: GRF, operand forwarding, branch/jump resolution, RI detection
// and the ID/EX register. Optional ID_BD_TRACK_EN adds the id_bd delay-slot marker.
module id_stage
  import id_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_pc4,
  input  logic [31:0] if_instr,
  input  logic        if_err,
  input  logic [4:0]  if_errstat,
  input  logic [1:0]  fwd_rs_sel,
  input  logic [1:0]  fwd_rt_sel,
  input  logic [31:0] ex_fwd_data,
  input  logic [31:0] mem_fwd_data,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
`ifdef ID_BD_TRACK_EN
  output logic        id_bd,
`endif
  output logic        branch,
  output logic        jump,
  output logic [31:0] branch_addr32,
  output logic [31:0] jump_addr32,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic [31:0] id_instr,
  output logic [31:0] id_rs_val,
  output logic [31:0] id_rt_val,
  output logic [31:0] id_imm32,
  output logic        id_err,
  output logic [4:0]  id_errstat
);

  logic [31:0] grf_rs;
  logic [31:0] grf_rt;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic [31:0] imm32;
  logic [15:0] imm16;
  dec_t        dec;
  logic        ctrl_block;
  logic        cond_true;
  idex_t       idex_q;
  idex_t       idex_normal;
  idex_t       idex_bubble;

  id_grf u_grf (
    .clk     (clk),
    .reset   (reset),
    .we      (wb_we),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .rs_addr (if_instr[25:21]),
    .rt_addr (if_instr[20:16]),
    .rs_data (grf_rs),
    .rt_data (grf_rt)
  );

  assign dec   = decode(if_instr[31:26], if_instr[5:0]);
  assign imm16 = if_instr[15:0];

  always_comb begin
    case (fwd_rs_sel)
      2'd1:    rs_val = ex_fwd_data;
      2'd2:    rs_val = mem_fwd_data;
      default: rs_val = grf_rs;
    endcase
    case (fwd_rt_sel)
      2'd1:    rt_val = ex_fwd_data;
      2'd2:    rt_val = mem_fwd_data;
      default: rt_val = grf_rt;
    endcase
  end

  always_comb begin
    case (dec.imm_kind)
      IMM_ZEXT: imm32 = {16'd0, imm16};
      IMM_LUI:  imm32 = {imm16, 16'd0};
      default:  imm32 = {{16{imm16[15]}}, imm16};
    endcase
  end

  // Redirects to IF are suppressed whenever this instruction will not retire from ID.
  assign ctrl_block    = stall | if_err | ~dec.legal;
  assign cond_true     = dec.is_beq ? (rs_val == rt_val) : (rs_val != rt_val);
  assign branch        = dec.is_branch & cond_true & ~ctrl_block;
  assign jump          = (dec.is_jump_imm | dec.is_jump_reg) & ~ctrl_block;
  assign branch_addr32 = if_pc4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jump_addr32   = dec.is_jump_reg ? rs_val : {if_pc4[31:28], if_instr[25:0], 2'b00};

  always_comb begin
    idex_normal.pc      = if_pc;
    idex_normal.pc8     = if_pc4 + 32'd4;
    idex_normal.instr   = if_err ? 32'd0 : if_instr;
    idex_normal.rs_val  = rs_val;
    idex_normal.rt_val  = rt_val;
    idex_normal.imm32   = imm32;
    idex_normal.err     = if_err | ~dec.legal;
    idex_normal.errstat = if_err ? if_errstat : (dec.legal ? ERR_NONE : ERR_RI);
  end

  // A bubble still carries the stalled instruction's PC so CP0 can report EPC.
  always_comb begin
    idex_bubble         = IDEX_RESET;
    idex_bubble.pc      = if_pc;
    idex_bubble.pc8     = if_pc4 + 32'd4;
  end

  // Stall holds ID and injects a bubble; flush squashes ID/EX; reset outranks both.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      idex_q <= IDEX_RESET;
    end else if (stall) begin
      idex_q <= idex_bubble;
    end else begin
      idex_q <= idex_normal;
    end
  end

`ifdef ID_BD_TRACK_EN
  logic last_ctrl;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      last_ctrl <= 1'b0;
      id_bd     <= 1'b0;
    end else if (stall) begin
      id_bd     <= 1'b0;
    end else begin
      id_bd     <= last_ctrl;
      last_ctrl <= dec.is_ctrl & ~if_err;
    end
  end
`endif

  assign id_pc      = idex_q.pc;
  assign id_pc8     = idex_q.pc8;
  assign id_instr   = idex_q.instr;
  assign id_rs_val  = idex_q.rs_val;
  assign id_rt_val  = idex_q.rt_val;
  assign id_imm32   = idex_q.imm32;
  assign id_err     = idex_q.err;
  assign id_errstat = idex_q.errstat;

endmodule

// File: tb/tb_id_stage.sv
// Directed and randomized bench for id_stage against a behavioural decode model.
// Build with +define+ID_BD_TRACK_EN to also cover the delay-slot marker.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [31:0] if_pc, if_pc4, if_instr;
  logic        if_err;
  logic [4:0]  if_errstat;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic [31:0] ex_fwd_data, mem_fwd_data;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        branch, jump;
  logic [31:0] branch_addr32, jump_addr32;
  logic [31:0] id_pc, id_pc8, id_instr, id_rs_val, id_rt_val, id_imm32;
  logic        id_err;
  logic [4:0]  id_errstat;
`ifdef ID_BD_TRACK_EN
  logic        id_bd;
`endif

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .if_pc(if_pc), .if_pc4(if_pc4), .if_instr(if_instr),
    .if_err(if_err), .if_errstat(if_errstat),
    .fwd_rs_sel(fwd_rs_sel), .fwd_rt_sel(fwd_rt_sel),
    .ex_fwd_data(ex_fwd_data), .mem_fwd_data(mem_fwd_data),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
`ifdef ID_BD_TRACK_EN
    .id_bd(id_bd),
`endif
    .branch(branch), .jump(jump),
    .branch_addr32(branch_addr32), .jump_addr32(jump_addr32),
    .id_pc(id_pc), .id_pc8(id_pc8), .id_instr(id_instr),
    .id_rs_val(id_rs_val), .id_rt_val(id_rt_val), .id_imm32(id_imm32),
    .id_err(id_err), .id_errstat(id_errstat)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  logic [31:0] m_grf [32];
  bit          m_last_ctrl;
  logic [31:0] e_pc, e_pc8, e_instr, e_rs, e_rt, e_imm;
  logic        e_err, e_bd;
  logic [4:0]  e_errstat;
  bit          e_vals;

  logic [5:0] r_fns [9]  = '{6'h00, 6'h08, 6'h09, 6'h0c, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2a};
  logic [5:0] i_ops [10] = '{6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    if (op == 6'h00) return fn inside {6'h00, 6'h08, 6'h09, 6'h0c, 6'h21, 6'h23, 6'h24, 6'h25, 6'h2a};
    return op inside {6'h02, 6'h03, 6'h04, 6'h05, 6'h09, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b};
  endfunction

  function automatic bit m_is_ctrl(input logic [31:0] ins);
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    return (op inside {6'h02, 6'h03, 6'h04, 6'h05}) || (op == 6'h00 && (fn inside {6'h08, 6'h09}));
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_grf[a];
  endfunction

  function automatic logic [31:0] m_operand(input logic [1:0] sel, input logic [4:0] a);
    if (sel == 2'd1) return ex_fwd_data;
    if (sel == 2'd2) return mem_fwd_data;
    return m_read(a);
  endfunction

  function automatic logic [31:0] m_imm(input logic [31:0] ins);
    logic [15:0] u;
    u = ins[15:0];
    if (ins[31:26] == 6'h0d || ins[31:26] == 6'h0c) return {16'h0000, u};
    if (ins[31:26] == 6'h0f) return {u, 16'h0000};
    return 32'($signed(u));
  endfunction

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0;
    if_pc = 32'h3000; if_pc4 = 32'h3004; if_instr = 32'd0;
    if_err = 0; if_errstat = 5'd31;
    fwd_rs_sel = 0; fwd_rt_sel = 0; ex_fwd_data = 0; mem_fwd_data = 0;
    wb_we = 0; wb_addr = 0; wb_data = 0;
  endtask

  // One clock: check ID-side combinational outputs, advance the model, check ID/EX.
  task automatic do_cycle();
    logic [31:0] ins, rsv, rtv;
    logic [5:0]  op, fn;
    bit          lg, ok, eb, ej;
    #1;
    ins = if_instr;
    op  = ins[31:26];
    fn  = ins[5:0];
    rsv = m_operand(fwd_rs_sel, ins[25:21]);
    rtv = m_operand(fwd_rt_sel, ins[20:16]);
    lg  = m_legal(ins);
    ok  = !stall && !if_err && lg;
    eb  = ok && ((op == 6'h04 && rsv == rtv) || (op == 6'h05 && rsv != rtv));
    ej  = ok && (op == 6'h02 || op == 6'h03 || (op == 6'h00 && (fn == 6'h08 || fn == 6'h09)));
    chk("branch", 32'(branch), 32'(eb));
    chk("jump", 32'(jump), 32'(ej));
    chk("branch_addr32", branch_addr32, if_pc4 + (32'($signed(ins[15:0])) << 2));
    if (ej) chk("jump_addr32", jump_addr32, (op == 6'h00) ? rsv : {if_pc4[31:28], ins[25:0], 2'b00});

    if (reset || flush) begin
      e_pc = 32'h3000; e_pc8 = 32'h3008; e_instr = 0; e_rs = 0; e_rt = 0; e_imm = 0;
      e_err = 0; e_errstat = 5'd31; e_bd = 0; m_last_ctrl = 0; e_vals = 1;
    end else if (stall) begin
      e_pc = if_pc; e_pc8 = if_pc4 + 32'd4; e_instr = 0;
      e_err = 0; e_errstat = 5'd31; e_bd = 0; e_vals = 0;
    end else begin
      e_pc = if_pc; e_pc8 = if_pc4 + 32'd4;
      e_instr = if_err ? 32'd0 : ins;
      e_rs = rsv; e_rt = rtv; e_imm = m_imm(ins);
      e_err = if_err || !lg;
      e_errstat = if_err ? if_errstat : (lg ? 5'd31 : 5'd10);
      e_bd = m_last_ctrl;
      m_last_ctrl = !if_err && m_is_ctrl(ins);
      e_vals = !if_err;
    end

    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
    end else if (wb_we && wb_addr != 5'd0) begin
      m_grf[wb_addr] = wb_data;
    end
    #1;
    chk("id_pc", id_pc, e_pc);
    chk("id_pc8", id_pc8, e_pc8);
    chk("id_instr", id_instr, e_instr);
    chk("id_err", 32'(id_err), 32'(e_err));
    chk("id_errstat", 32'(id_errstat), 32'(e_errstat));
    if (e_vals) begin
      chk("id_rs_val", id_rs_val, e_rs);
      chk("id_rt_val", id_rt_val, e_rt);
      chk("id_imm32", id_imm32, e_imm);
    end
`ifdef ID_BD_TRACK_EN
    chk("id_bd", 32'(id_bd), 32'(e_bd));
`endif
  endtask

  initial begin
    logic [31:0] ins;
    logic [4:0]  ra, rb, rc;
    int          kind;
    for (int i = 0; i < 32; i++) m_grf[i] = 32'd0;
    m_last_ctrl = 0;
    idle_inputs();

    // Reset state and an all-zero register file
    reset = 1;
    do_cycle();
    do_cycle();
    chk("rst_instr", id_instr, 32'd0);
    chk("rst_pc", id_pc, 32'h3000);
    chk("rst_errstat", 32'(id_errstat), 32'd31);
    reset = 0;
    for (int i = 1; i < 32; i++) begin
      if_instr = {6'h00, 5'(i), 5'(i), 5'd0, 5'd0, 6'h21};
      do_cycle();
      chk("grf_zero_rs", id_rs_val, 32'd0);
      chk("grf_zero_rt", id_rt_val, 32'd0);
    end

    // Write-through and $0 immutability
    wb_we = 1; wb_addr = 5'd5; wb_data = 32'h1234;
    if_instr = {6'h00, 5'd5, 5'd0, 5'd3, 5'd0, 6'h21};
    do_cycle();
    chk("wt_rs", id_rs_val, 32'h1234);
    wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    if_instr = {6'h00, 5'd0, 5'd5, 5'd3, 5'd0, 6'h21};
    do_cycle();
    chk("r0_wt", id_rs_val, 32'd0);
    wb_we = 0;
    do_cycle();
    chk("r0_after", id_rs_val, 32'd0);
    chk("r5_after", id_rt_val, 32'h1234);

    // beq with forwarded rs, then the same case under stall
    wb_we = 1; wb_addr = 5'd1; wb_data = 32'h11; if_instr = 0;
    do_cycle();
    wb_addr = 5'd2; wb_data = 32'h22;
    do_cycle();
    wb_we = 0;
    if_instr = {6'h04, 5'd1, 5'd2, 16'hFFFF};
    if_pc = 32'h3004; if_pc4 = 32'h3008;
    fwd_rs_sel = 2'd1; ex_fwd_data = 32'h22;
    do_cycle();
    chk("beq_taken", 32'(branch), 32'd1);
    chk("beq_target", branch_addr32, 32'h3004);
    stall = 1;
    do_cycle();
    chk("beq_stall", 32'(branch), 32'd0);
    chk("stall_instr", id_instr, 32'd0);
    stall = 0; fwd_rs_sel = 0;

    // Reserved instruction, then IF-side exception priority
    if_instr = 32'hFC00_0000;
    do_cycle();
    chk("ri_err", 32'(id_err), 32'd1);
    chk("ri_code", 32'(id_errstat), 32'd10);
    if_err = 1; if_errstat = 5'd4;
    do_cycle();
    chk("iferr_code", 32'(id_errstat), 32'd4);
    chk("iferr_instr", id_instr, 32'd0);
    if_err = 0; if_errstat = 5'd31;

    // Flush beats stall; reset beats stall
    stall = 1; flush = 1; if_pc = 32'h5000; if_pc4 = 32'h5004; if_instr = 32'h0022_1821;
    do_cycle();
    chk("flush_pc", id_pc, 32'h3000);
    flush = 0; reset = 1;
    do_cycle();
    chk("rst_stall_pc", id_pc, 32'h3000);
    reset = 0; stall = 0;

    // jr $31
    wb_we = 1; wb_addr = 5'd31; wb_data = 32'h3100; if_instr = 0;
    do_cycle();
    wb_we = 0;
    if_instr = {6'h00, 5'd31, 15'd0, 6'h08};
    do_cycle();
    chk("jr_jump", 32'(jump), 32'd1);
    chk("jr_target", jump_addr32, 32'h3100);

`ifdef ID_BD_TRACK_EN
    if_instr = {6'h03, 26'h000_0100};
    do_cycle();
    if_instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    do_cycle();
    chk("bd_addu", 32'(id_bd), 32'd1);
    if_instr = {6'h03, 26'h000_0200};
    do_cycle();
    if_instr = {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h21};
    stall = 1;
    do_cycle();
    chk("bd_bubble", 32'(id_bd), 32'd0);
    stall = 0;
    do_cycle();
    chk("bd_after_stall", 32'(id_bd), 32'd1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 21));
      ra = 5'($urandom_range(0, 7));
      rb = 5'($urandom_range(0, 7));
      rc = 5'($urandom_range(0, 31));
      if (kind < 9)       ins = {6'h00, ra, rb, rc, 5'($urandom_range(0, 31)), r_fns[kind]};
      else if (kind < 19) ins = {i_ops[kind - 9], ra, rb, 16'($urandom)};
      else if (kind == 19) ins = 32'd0;
      else                 ins = $urandom;
      if_instr     = ins;
      if_pc        = {$urandom, 2'b00};
      if_pc4       = if_pc + 32'd4;
      fwd_rs_sel   = 2'($urandom_range(0, 3));
      fwd_rt_sel   = 2'($urandom_range(0, 3));
      ex_fwd_data  = 32'($urandom_range(0, 3));
      mem_fwd_data = 32'($urandom_range(0, 3));
      wb_we        = ($urandom_range(0, 1) == 1);
      wb_addr      = 5'($urandom_range(0, 7));
      wb_data      = 32'($urandom_range(0, 3));
      stall        = ($urandom_range(0, 4) == 0);
      flush        = ($urandom_range(0, 19) == 0);
      reset        = ($urandom_range(0, 99) == 0);
      if_err       = ($urandom_range(0, 15) == 0);
      if_errstat   = 5'($urandom_range(0, 31));
      do_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
